// File: rtl/alu_serial_sequencer.sv
// Bit-serial MIPS ALU controller: drives one external 1-bit ALU slice LSB first.
// Optional `ALU_SERIAL_ILLEGAL_EN adds illegal_op and forces a zero result for unlisted alu_ctrl codes.
module alu_serial_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             done,
  output logic             busy,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_ainvert,
  output logic             slice_binvert,
  output logic             slice_carryin,
  output logic [1:0]       slice_operation,
  output logic             slice_less,
  input  logic             slice_result,
  input  logic             slice_carryout
`ifdef ALU_SERIAL_ILLEGAL_EN
  ,
  output logic             illegal_op
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RES_W = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic [1:0] op;
    logic       cin;
    logic       arith;
    logic       slt;
  } ctrl_t;

  // Unlisted codes fall through to the AND configuration.
  function automatic ctrl_t decode_ctrl(input logic [3:0] code);
    ctrl_t c;
    c = '0;
    case (code)
      4'b0001: c.op = 2'b01;
      4'b0010: begin
        c.op    = 2'b10;
        c.arith = 1'b1;
      end
      4'b0110: begin
        c.binv  = 1'b1;
        c.op    = 2'b10;
        c.cin   = 1'b1;
        c.arith = 1'b1;
      end
      4'b0111: begin
        c.binv  = 1'b1;
        c.op    = 2'b10;
        c.cin   = 1'b1;
        c.arith = 1'b1;
        c.slt   = 1'b1;
      end
      4'b1100: begin
        c.ainv = 1'b1;
        c.binv = 1'b1;
      end
      default: c.op = 2'b00;
    endcase
    return c;
  endfunction

`ifdef ALU_SERIAL_ILLEGAL_EN
  function automatic logic is_listed(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
`endif

  state_t             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [RES_W-1:0]   res_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               ainv_q;
  logic               binv_q;
  logic [1:0]         op_q;
  logic               arith_q;
  logic               slt_q;
  logic               a0_q;
  logic               b0_q;
  logic               set_bit_q;
  logic               ov_slt_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               ovf_q;
  logic               done_q;
`ifdef ALU_SERIAL_ILLEGAL_EN
  logic               illegal_q;
  logic               illegal_op_q;
`endif

  ctrl_t              dec;
  logic               accept;
  logic               last_bit;
  logic               ov_now;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_ovf;

  assign dec      = decode_ctrl(alu_ctrl);
  assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign accept   = start && ready;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // In RUN the slice carry-in is carry_q, so this is carry-in ^ carry-out of the MSB.
  assign ov_now   = arith_q & (carry_q ^ slice_carryout);

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign done     = done_q;
`ifdef ALU_SERIAL_ILLEGAL_EN
  assign illegal_op = illegal_op_q;
`endif

  always_comb begin
    fin_result = {slice_result, res_sh_q};
    fin_ovf    = ov_now;
`ifdef ALU_SERIAL_ILLEGAL_EN
    if (illegal_q) begin
      fin_result = '0;
      fin_ovf    = 1'b0;
    end
`endif
  end

  always_comb begin
    slice_a         = 1'b0;
    slice_b         = 1'b0;
    slice_ainvert   = 1'b0;
    slice_binvert   = 1'b0;
    slice_carryin   = 1'b0;
    slice_operation = 2'b00;
    slice_less      = 1'b0;
    case (state_q)
      S_RUN: begin
        slice_a         = a_sh_q[0];
        slice_b         = b_sh_q[0];
        slice_ainvert   = ainv_q;
        slice_binvert   = binv_q;
        slice_carryin   = carry_q;
        slice_operation = op_q;
      end
      // SLT fix-up: bit 0 of the result is the sign-corrected set bit fed through Less.
      S_FIX: begin
        slice_a         = a0_q;
        slice_b         = b0_q;
        slice_binvert   = 1'b1;
        slice_carryin   = 1'b1;
        slice_operation = 2'b11;
        slice_less      = set_bit_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      ainv_q       <= 1'b0;
      binv_q       <= 1'b0;
      op_q         <= 2'b00;
      arith_q      <= 1'b0;
      slt_q        <= 1'b0;
      a0_q         <= 1'b0;
      b0_q         <= 1'b0;
      set_bit_q    <= 1'b0;
      ov_slt_q     <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
`ifdef ALU_SERIAL_ILLEGAL_EN
      illegal_q    <= 1'b0;
      illegal_op_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef ALU_SERIAL_ILLEGAL_EN
      illegal_op_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_sh_q    <= a;
            b_sh_q    <= b;
            a0_q      <= a[0];
            b0_q      <= b[0];
            res_sh_q  <= '0;
            cnt_q     <= '0;
            carry_q   <= dec.cin;
            ainv_q    <= dec.ainv;
            binv_q    <= dec.binv;
            op_q      <= dec.op;
            arith_q   <= dec.arith;
            slt_q     <= dec.slt;
            set_bit_q <= 1'b0;
            ov_slt_q  <= 1'b0;
`ifdef ALU_SERIAL_ILLEGAL_EN
            illegal_q <= !is_listed(alu_ctrl);
`endif
            state_q   <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= RES_W'({slice_result, res_sh_q} >> 1);
          carry_q  <= slice_carryout;
          cnt_q    <= cnt_q + 1'b1;
          if (last_bit) begin
            if (slt_q) begin
              ov_slt_q  <= ov_now;
              set_bit_q <= slice_result ^ ov_now;
              state_q   <= S_FIX;
            end else begin
              result_q <= fin_result;
              zero_q   <= (fin_result == '0);
              ovf_q    <= fin_ovf;
              done_q   <= 1'b1;
`ifdef ALU_SERIAL_ILLEGAL_EN
              illegal_op_q <= illegal_q;
`endif
              state_q  <= S_DONE;
            end
          end
        end
        S_FIX: begin
          result_q <= {{(WIDTH-1){1'b0}}, slice_result};
          zero_q   <= !slice_result;
          ovf_q    <= ov_slt_q;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural 1-bit ALU slice attached.
module tb_alu_serial_sequencer;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    alu_ctrl = 4'b0000;
  logic          ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;
  logic          done;
  logic          busy;
  logic          slice_a;
  logic          slice_b;
  logic          slice_ainvert;
  logic          slice_binvert;
  logic          slice_carryin;
  logic [1:0]    slice_operation;
  logic          slice_less;
  logic          slice_result;
  logic          slice_carryout;
`ifdef ALU_SERIAL_ILLEGAL_EN
  logic          illegal_op;
`endif

  int   n_tests = 0;
  int   n_fail = 0;
  int   lat;
  int   dones;
  logic fb_binv;
  logic fb_cin;
  logic fb_busy;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .a(a), .b(b), .alu_ctrl(alu_ctrl),
    .result(result), .zero(zero), .overflow(overflow), .done(done), .busy(busy),
    .slice_a(slice_a), .slice_b(slice_b), .slice_ainvert(slice_ainvert),
    .slice_binvert(slice_binvert), .slice_carryin(slice_carryin),
    .slice_operation(slice_operation), .slice_less(slice_less),
    .slice_result(slice_result), .slice_carryout(slice_carryout)
`ifdef ALU_SERIAL_ILLEGAL_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  // Reference 1-bit MIPS ALU slice
  logic m_a, m_b;
  always_comb begin
    m_a            = slice_a ^ slice_ainvert;
    m_b            = slice_b ^ slice_binvert;
    slice_carryout = (m_a & m_b) | (m_a & slice_carryin) | (m_b & slice_carryin);
    case (slice_operation)
      2'b00:   slice_result = m_a & m_b;
      2'b01:   slice_result = m_a | m_b;
      2'b10:   slice_result = m_a ^ m_b ^ slice_carryin;
      default: slice_result = slice_less;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge; returns at the negedge where done is seen.
  // lat counts rising edges starting with the accept edge.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit hold);
    alu_ctrl = c;
    a        = x;
    b        = y;
    start    = 1'b1;
    lat      = 0;
    fb_binv  = 1'b0;
    fb_cin   = 1'b0;
    fb_busy  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        fb_binv = slice_binvert;
        fb_cin  = slice_carryin;
        fb_busy = busy;
        if (hold) begin
          alu_ctrl = 4'b0110;
          a        = 32'd100;
          b        = 32'd200;
        end else begin
          start = 1'b0;
        end
      end
      if (done) break;
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", ready, 1'b1);
    chk("idle_slice_op", slice_operation, 2'b00);

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("add_lat", lat, 33);
    chk("add_result", result, 32'h8000_0000);
    chk("add_ovf", overflow, 1'b1);
    chk("add_zero", zero, 1'b0);
    @(negedge clk);
    chk("add_done_pulse", done, 1'b0);
    chk("add_ready_after", ready, 1'b1);

    run_op(4'b0110, 32'd5, 32'd5, 1'b0);
    chk("sub_binv_first", fb_binv, 1'b1);
    chk("sub_cin_first", fb_cin, 1'b1);
    chk("sub_lat", lat, 33);
    chk("sub_result", result, 32'h0);
    chk("sub_zero", zero, 1'b1);
    chk("sub_ovf", overflow, 1'b0);
    @(negedge clk);

    run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("slt_neg_lat", lat, 34);
    chk("slt_neg_result", result, 32'h1);
    chk("slt_neg_ovf", overflow, 1'b0);
    chk("slt_neg_zero", zero, 1'b0);
    @(negedge clk);

    run_op(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    chk("slt_pos_result", result, 32'h0);
    chk("slt_pos_zero", zero, 1'b1);
    @(negedge clk);

    run_op(4'b0111, 32'h8000_0000, 32'h0000_0001, 1'b0);
    chk("slt_ovf_result", result, 32'h1);
    chk("slt_ovf_flag", overflow, 1'b1);
    @(negedge clk);

    run_op(4'b0001, 32'h1234_0000, 32'h0000_5678, 1'b0);
    chk("or_result", result, 32'h1234_5678);
    chk("or_ovf", overflow, 1'b0);
    @(negedge clk);

    run_op(4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F00, 1'b0);
    chk("nor_result", result, 32'h0000_000F);
    run_op(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    chk("b2b_busy_first", fb_busy, 1'b1);
    chk("b2b_lat", lat, 33);
    chk("and_result", result, 32'h0F00_0F00);
    repeat (3) @(negedge clk);
    chk("hold_result", result, 32'h0F00_0F00);
    chk("hold_done", done, 1'b0);

    alu_ctrl = 4'b0010;
    a        = 32'd3;
    b        = 32'd4;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("accept_keeps_result", result, 32'h0F00_0F00);
    chk("run_busy", busy, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("run_slice_op", slice_operation, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("arst_result", result, 32'h0);
    chk("arst_flags", {zero, overflow, done, busy}, 4'b0000);
    chk("arst_slice", {slice_a, slice_b, slice_ainvert, slice_binvert, slice_carryin,
                       slice_operation, slice_less}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", ready, 1'b1);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("arst_no_done", dones, 0);

    run_op(4'b0010, 32'd3, 32'd4, 1'b0);
    chk("add_after_rst", result, 32'd7);
    @(negedge clk);

    run_op(4'b0010, 32'd10, 32'd20, 1'b1);
    chk("held_start_lat", lat, 33);
    chk("held_start_result", result, 32'd30);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("held_start_one_done", dones, 0);

    run_op(4'b1111, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0);
`ifdef ALU_SERIAL_ILLEGAL_EN
    chk("ill_flag", illegal_op, 1'b1);
    chk("ill_result", result, 32'h0);
    chk("ill_zero", zero, 1'b1);
    chk("ill_ovf", overflow, 1'b0);
    @(negedge clk);
    chk("ill_flag_pulse", illegal_op, 1'b0);
`else
    chk("unlisted_result", result, 32'h0F0F_0000);
    chk("unlisted_zero", zero, 1'b0);
    chk("unlisted_ovf", overflow, 1'b0);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
Multi-cycle controller that drives one external 1-bit ALU slice, one bit per cycle, LSB first, to perform WIDTH-bit MIPS ALU operations.
- Owns the slice's control inputs and the carry feedback path.
- Collects the Result bits and produces result, zero and overflow.
- Sits between the decode/issue logic (start/ready handshake) and a single slice instance. Used in area-reduced cores in place of a WIDTH-slice ripple ALU.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted when start && ready
ready  out  1  sequencer can accept a request
a  in  WIDTH  operand A, sampled on accept
b  in  WIDTH  operand B, sampled on accept
alu_ctrl  in  4  MIPS ALU control, sampled on accept
result  out  WIDTH  operation result, held until next accept
zero  out  1  result == 0, valid with done
overflow  out  1  signed overflow (ADD/SUB/SLT only), valid with done
done  out  1  one-cycle pulse: result/flags valid
busy  out  1  operation in progress
slice_a  out  1  to slice a
slice_b  out  1  to slice b
slice_ainvert  out  1  to slice Ainvert
slice_binvert  out  1  to slice Binvert
slice_carryin  out  1  to slice CarryIn
slice_operation  out  2  to slice Operation (00 AND, 01 OR, 10 ADD, 11 SLT)
slice_less  out  1  to slice Less
slice_result  in  1  from slice Result (combinational)
slice_carryout  in  1  from slice CarryOut (combinational)

Behaviour:
- One clock domain; rst_n asynchronous, active-low.
- Reset, including mid-operation:
  - state=IDLE; result=0; zero=0; overflow=0; done=0; busy=0.
  - All operand/shift/carry registers cleared; in-flight operation discarded.
- Decode (alu_ctrl -> Ainvert, Binvert, Operation, initial carry):
  - 0000 AND: 0,0,00,0
  - 0001 OR: 0,0,01,0
  - 0010 ADD: 0,0,10,0
  - 0110 SUB: 0,1,10,1
  - 0111 SLT: 0,1,10,1 during RUN, then FIX
  - 1100 NOR: 1,1,00,0
- ready=1 in IDLE and DONE states, else 0. busy=1 in RUN and FIX.
- start while not ready is ignored; no queuing.
- States:
  - IDLE: slice_* outputs all 0. On accept: latch a, b, decoded controls; bit counter=0; carry register=initial carry; go to RUN.
  - RUN, one cycle per bit i=0..WIDTH-1:
    - slice_a=a_sh[0], slice_b=b_sh[0], slice_carryin=carry register, slice_less=0.
    - Each cycle: a_sh, b_sh shift right; result shift register <= {slice_result, res[WIDTH-1:1]}; carry register <= slice_carryout.
    - At i=WIDTH-1: overflow <= slice_carryin ^ slice_carryout for ADD/SUB/SLT, else 0; set_bit <= slice_result ^ that overflow.
    - Go to FIX if SLT, else DONE.
  - FIX (SLT only, one cycle):
    - Drive slice_a=a[0], slice_b=b[0], Binvert=1, Operation=11, slice_less=set_bit.
    - result <= {WIDTH-1 zeros, slice_result}. Go to DONE.
  - DONE (one cycle): done=1, zero=(result==0). Accept in DONE goes directly to RUN (back-to-back); otherwise go to IDLE.
- Latency from accept edge to done high: WIDTH+1 cycles (ADD/SUB/AND/OR/NOR); WIDTH+2 cycles (SLT).
- overflow for SLT reflects the A-B subtraction.
- result/zero/overflow hold their values until the next operation completes; they are not cleared on accept.

Optional Feature:
ALU_SERIAL_ILLEGAL_EN
- Defined: adds output port illegal_op (1 bit, reset 0).
  - An unlisted alu_ctrl code still runs the full RUN sequence as AND.
  - At completion: result forced to 0, zero=1, overflow=0, illegal_op=1 for the done cycle only.
- Undefined: no port. Unlisted codes execute as AND with normal result and flags.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, overflow=1, zero=0, done exactly 33 cycles after accept.
- SUB a=5, b=5 -> result=0, zero=1, overflow=0; slice_binvert=1 and slice_carryin=1 on the first RUN cycle.
- SLT a=0xFFFFFFFF, b=1 -> result=1, done 34 cycles after accept. SLT a=1, b=0xFFFFFFFF -> result=0.
- NOR a=0xF0F0F0F0, b=0x0F0F0F00 -> result=0x0000000F. Issue start in the DONE cycle with AND 0xFF00FF00 & 0x0FF00FF0 -> accepted (no IDLE cycle), result=0x0F000F00.
- Start ADD 3+4, drop rst_n at RUN bit 10 -> all outputs 0 immediately, ready=1 after release, no done. A new ADD 3+4 -> result=7.
- start asserted throughout busy -> only the first request executes, exactly one done pulse. With ALU_SERIAL_ILLEGAL_EN, alu_ctrl=1111 -> illegal_op=1, result=0, zero=1.
